// File: rtl/frame_parity_pkg.sv
// Shared types and helpers for the frame parity checker: FSM state encoding
// and a reduction-XOR helper usable for any data width up to PARITY_MAX_W.
package frame_parity_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int PARITY_MAX_W = 1024;

    // Callers zero-extend narrower words; extra zero bits do not change the XOR.
    function automatic logic parity_reduce(input logic [PARITY_MAX_W-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/frame_parity_checker_sat_counter.sv
// Saturating beat counter: counts up to LIMIT, then holds and raises a sticky
// saturation flag on every further increment until cleared.
module sat_counter #(
    parameter int CNT_W = 5,
    parameter int LIMIT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o,
    output logic             sat_o
);

    logic [CNT_W-1:0] count_q, count_d;
    logic             sat_q, sat_d;

    always_comb begin
        count_d = count_q;
        sat_d   = sat_q;
        if (clr_i) begin
            count_d = '0;
            sat_d   = 1'b0;
        end else if (inc_i) begin
            if (count_q == CNT_W'(LIMIT)) begin
                sat_d = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            sat_q   <= sat_d;
        end
    end

    assign count_o = count_q;
    assign sat_o   = sat_q;

endmodule

// File: rtl/frame_parity_checker.sv
// Frame-based parity accumulator: folds the XOR of every accepted beat into a
// running parity and reports parity, mismatch, beat count and overflow per frame.
module frame_parity_checker
    import frame_parity_pkg::*;
#(
    parameter  int WIDTH     = 2,
    parameter  int MAX_BEATS = 16,
    localparam int CNT_W     = $clog2(MAX_BEATS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             in_parity,
    input  logic             odd_mode,
    output logic             run_parity,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_parity,
    output logic             out_error,
    output logic             out_overflow,
    output logic [CNT_W-1:0] out_beats
);

    state_e     state_q, state_d;
    logic       acc_q, acc_d;
    logic       mode_q, mode_d;
    logic       ipar_q, ipar_d;
    logic       cnt_inc, cnt_clr;
    logic       beat_par;
    logic [CNT_W-1:0] cnt;
    logic       cnt_sat;

    assign beat_par = parity_reduce(PARITY_MAX_W'(in_data));

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        mode_d  = mode_q;
        ipar_d  = ipar_q;
        cnt_inc = 1'b0;
        cnt_clr = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    acc_d   = beat_par;
                    mode_d  = odd_mode;
                    cnt_inc = 1'b1;
                    if (in_last) begin
                        ipar_d  = in_parity;
                        state_d = DONE;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            ACCUM: begin
                // Mode stays as latched on the first beat; odd_mode is ignored here.
                if (in_valid) begin
                    acc_d   = acc_q ^ beat_par;
                    cnt_inc = 1'b1;
                    if (in_last) begin
                        ipar_d  = in_parity;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    acc_d   = 1'b0;
                    mode_d  = 1'b0;
                    ipar_d  = 1'b0;
                    cnt_clr = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            acc_q   <= 1'b0;
            mode_q  <= 1'b0;
            ipar_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            mode_q  <= mode_d;
            ipar_q  <= ipar_d;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W),
        .LIMIT (MAX_BEATS)
    ) u_beat_cnt (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (cnt_clr),
        .inc_i   (cnt_inc),
        .count_o (cnt),
        .sat_o   (cnt_sat)
    );

    // All result outputs come straight from registers; cleared state reads as 0 in IDLE.
    assign in_ready     = (state_q != DONE);
    assign out_valid    = (state_q == DONE);
    assign run_parity   = acc_q ^ mode_q;
    assign out_parity   = acc_q ^ mode_q;
    assign out_error    = (acc_q ^ mode_q) ^ ipar_q;
    assign out_beats    = cnt;
    assign out_overflow = cnt_sat;

endmodule

// File: tb/tb_frame_parity_checker.sv
// Scoreboard bench for frame_parity_checker: directed and random frames, expected
// results pushed at issue time and checked by an independent output monitor.
module tb_frame_parity_checker;

    localparam int WIDTH     = 2;
    localparam int MAXB      = 4;
    localparam int CNT_W     = $clog2(MAXB + 1);

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             in_parity;
    logic             odd_mode;
    logic             run_parity;
    logic             out_valid;
    logic             out_ready;
    logic             out_parity;
    logic             out_error;
    logic             out_overflow;
    logic [CNT_W-1:0] out_beats;

    frame_parity_checker #(.WIDTH(WIDTH), .MAX_BEATS(MAXB)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .in_parity    (in_parity),
        .odd_mode     (odd_mode),
        .run_parity   (run_parity),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_parity   (out_parity),
        .out_error    (out_error),
        .out_overflow (out_overflow),
        .out_beats    (out_beats)
    );

    typedef struct {
        logic             par;
        logic             err;
        logic             ovf;
        logic [CNT_W-1:0] beats;
    } exp_t;

    exp_t             sbq[$];
    logic [WIDTH-1:0] dat[0:15];
    int               nchecks = 0;
    int               errs    = 0;
    bit               rand_rdy = 0;
    bit               gaps     = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit word_par(input logic [WIDTH-1:0] d);
        return ($countones(d) % 2) == 1;
    endfunction

    // Random consumer backpressure, driven just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: every consumed result is compared against the oldest expectation.
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                chk("unexpected_result", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("out_parity", 32'(out_parity), 32'(e.par));
                chk("out_error", 32'(out_error), 32'(e.err));
                chk("out_overflow", 32'(out_overflow), 32'(e.ovf));
                chk("out_beats", 32'(out_beats), 32'(e.beats));
            end
        end
    end

    task automatic wait_accept();
        int t = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 200) begin
                chk("accept_timeout", 32'd1, 32'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Drives n beats from dat[]; the expected frame result is computed from the
    // whole frame up front: XOR of all data bits, mode from the first beat.
    task automatic run_frame(input int n, input bit odd, input bit ip, input bit push, input bit term);
        bit   total = 0;
        bit   run   = 0;
        exp_t e;
        for (int i = 0; i < n; i++) total ^= word_par(dat[i]);
        if (push) begin
            e.par   = total ^ odd;
            e.err   = total ^ odd ^ ip;
            e.ovf   = (n > MAXB);
            e.beats = CNT_W'((n > MAXB) ? MAXB : n);
            sbq.push_back(e);
        end
        for (int i = 0; i < n; i++) begin
            if (gaps && ($urandom_range(0, 3) == 0)) begin
                in_valid = 0;
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
            in_valid  = 1;
            in_data   = dat[i];
            in_last   = term && (i == n - 1);
            odd_mode  = (i == 0) ? odd : ~odd;
            in_parity = (i == n - 1) ? ip : 1'($urandom_range(0, 1));
            wait_accept();
            run ^= word_par(dat[i]);
            chk("run_parity", 32'(run_parity), 32'(run ^ odd));
        end
        in_valid = 0;
        in_last  = 0;
    endtask

    task automatic drain();
        int t = 0;
        while (sbq.size() != 0 && t < 500) begin
            @(posedge clk);
            t++;
        end
        chk("drain_empty", 32'(sbq.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_run_parity"}, 32'(run_parity), 32'd0);
        chk({tag, "_out_parity"}, 32'(out_parity), 32'd0);
        chk({tag, "_out_error"}, 32'(out_error), 32'd0);
        chk({tag, "_out_overflow"}, 32'(out_overflow), 32'd0);
        chk({tag, "_out_beats"}, 32'(out_beats), 32'd0);
    endtask

    initial begin
        logic [WIDTH-1:0] singles[0:3];
        bit               p0;
        logic [CNT_W-1:0] b0;
        reset = 0; in_valid = 0; in_data = 0; in_last = 0;
        in_parity = 0; odd_mode = 0; out_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        @(negedge clk);
        reset = 1;
        @(posedge clk);
        #1;

        // Single-beat even frames
        singles[0] = 2'b00; singles[1] = 2'b01; singles[2] = 2'b11; singles[3] = 2'b10;
        for (int i = 0; i < 4; i++) begin
            dat[0] = singles[i];
            run_frame(1, 0, 0, 1, 1);
        end

        // Three-beat frame with matching and mismatching expected parity
        dat[0] = 2'b01; dat[1] = 2'b11; dat[2] = 2'b10;
        run_frame(3, 0, 0, 1, 1);
        run_frame(3, 0, 1, 1, 1);

        // Odd mode latched on first beat, toggled afterwards
        dat[0] = 2'b01; dat[1] = 2'b01;
        run_frame(2, 1, 0, 1, 1);

        // Overflow: six beats into a four-beat limit
        for (int i = 0; i < 6; i++) dat[i] = WIDTH'($urandom);
        run_frame(6, 0, 1, 1, 1);
        drain();

        // Backpressure in DONE with the next beat already waiting
        out_ready = 0;
        fork
            begin
                dat[0] = 2'b10;
                run_frame(1, 0, 0, 1, 1);
                dat[0] = 2'b11;
                run_frame(1, 1, 1, 1, 1);
            end
            begin
                int t = 0;
                do begin
                    @(negedge clk);
                    t++;
                end while (!out_valid && t < 50);
                p0 = out_parity;
                b0 = out_beats;
                repeat (5) begin
                    @(negedge clk);
                    chk("bp_out_valid", 32'(out_valid), 32'd1);
                    chk("bp_in_ready", 32'(in_ready), 32'd0);
                    chk("bp_out_parity", 32'(out_parity), 32'(p0));
                    chk("bp_out_beats", 32'(out_beats), 32'(b0));
                end
                @(posedge clk);
                #1;
                out_ready = 1;
                @(negedge clk);
                @(posedge clk);
                @(negedge clk);
                chk("bp_release_in_ready", 32'(in_ready), 32'd1);
            end
        join
        drain();

        // Reset in the middle of a frame discards it
        for (int i = 0; i < 3; i++) dat[i] = WIDTH'($urandom);
        run_frame(3, 1, 0, 0, 0);
        #2;
        reset = 0;
        #1;
        chk_reset_vals("midreset");
        @(negedge clk);
        reset = 1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) dat[i] = WIDTH'($urandom);
        run_frame(3, 0, 1, 1, 1);
        drain();

        // Random frames with gaps and random consumer backpressure
        gaps     = 1;
        rand_rdy = 1;
        for (int f = 0; f < 40; f++) begin
            int n;
            n = $urandom_range(1, 7);
            for (int i = 0; i < n; i++) dat[i] = WIDTH'($urandom);
            run_frame(n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1, 1);
        end
        rand_rdy = 0;
        #2;
        out_ready = 1;
        drain();

        $display("Result: errors=%0d of %0d checks", errs, nchecks);
        $finish;
    end

endmodule

// File: doc/frame_parity_checker.md
# frame_parity_checker

Parametrised, frame-based parity accumulator with valid/ready handshakes. Folds the XOR of every data bit of every accepted beat into a running parity bit, applies even/odd mode, and on the last beat of a frame presents the result, a mismatch flag against a supplied parity bit, the beat count and an overflow flag. It is the multi-bit, multi-beat successor of the team's 1-bit x/y toggle machine: WIDTH=2, single-beat frames, even mode reproduce that behaviour on `run_parity`.

## Interface
- WIDTH, 2, data bits per beat (≥1)
- MAX_BEATS, 16, beats per frame before overflow (≥1)
- CNT_W, $clog2(MAX_BEATS+1), derived; width of beat count
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- in_data  in  WIDTH  beat data
- in_last  in  1  beat is last of frame
- in_parity  in  1  expected parity; sampled with the last beat only
- odd_mode  in  1  0 = even (parity = XOR), 1 = odd (parity = ~XOR); sampled on a frame's first beat
- run_parity  out  1  running parity of the current frame, mode applied
- out_valid  out  1  frame result valid
- out_ready  in  1  consumer accepts result
- out_parity  out  1  frame parity
- out_error  out  1  out_parity != latched in_parity
- out_overflow  out  1  frame carried more than MAX_BEATS beats
- out_beats  out  CNT_W  beats in frame, saturating at MAX_BEATS

## Operation
- Beat accepted iff in_valid && in_ready. Result consumed iff out_valid && out_ready.
- States: IDLE, ACCUM, DONE. in_ready = (state != DONE); out_valid = (state == DONE).
- IDLE, beat accepted: acc = ^in_data; mode latched from odd_mode; count = 1; overflow = 0; to DONE if in_last (latch in_parity), else ACCUM.
- ACCUM, beat accepted: acc ^= ^in_data; if count == MAX_BEATS, overflow set (sticky) and count held, else count+1; to DONE if in_last (latch in_parity). odd_mode ignored mid-frame.
- DONE: outputs stable while out_ready low. On consume: acc, count, overflow, mode cleared; to IDLE. No beat accepted in DONE, including the consume cycle.
- run_parity = acc ^ mode; 0 in IDLE; equals out_parity in DONE.
- out_parity = acc ^ mode; out_error = out_parity ^ latched in_parity; out_beats = count; out_overflow = overflow. Outputs other than in_ready/out_valid are don't-care-free: they show cleared values (0) in IDLE.
- in_last on an overflowed frame still terminates it; overflow reported, parity covers all beats including those beyond MAX_BEATS.
- Reset asserted at any time (mid-frame or in DONE): immediate return to IDLE, partial frame discarded.

## Timing
- Reset values: in_ready 1, out_valid 0, run_parity 0, out_parity 0, out_error 0, out_overflow 0, out_beats 0.
- All outputs registered or decoded from state; no combinational path from in_* or out_ready to any output.
- Last beat accepted at edge N -> out_valid high after edge N. Consumed at edge M -> in_ready high after edge M.
- Throughput: k-beat frame occupies at least k+1 cycles; single-beat frames at best one every 2 cycles.
- run_parity updates after the edge on which a beat is accepted.

## Structure
- Package frame_parity_pkg: state enum (IDLE, ACCUM, DONE) and a parity-reduce function for WIDTH-bit words.
- One sub-module natural: sat_counter (CNT_W-bit, limit MAX_BEATS, clear, increment, saturate flag), used for count/overflow.

## Test plan
- Reset: hold reset low mid-frame after 3 beats -> all outputs at reset values, in_ready 1; next frame counts from 1.
- WIDTH=2, even, single beats 2'b00, 2'b01, 2'b11, 2'b10 each with in_last, out_ready=1 -> out_parity 0,1,0,1; out_beats 1 each.
- Even mode, 3-beat frame 2'b01, 2'b11, 2'b10, in_parity=0 -> out_parity 0, out_error 0, out_beats 3; repeat with in_parity=1 -> out_error 1.
- Odd mode on first beat, toggle odd_mode mid-frame, data 2'b01, 2'b01 -> out_parity 1 (mode not resampled).
- MAX_BEATS=4, 6-beat frame -> out_overflow 1, out_beats 4, parity covers all 6 beats.
- Backpressure: out_ready low 5 cycles in DONE while in_valid high -> outputs stable, in_ready 0, no beat lost; release -> in_ready 1 next cycle, next beat accepted.
